// File: rtl/bidir_port_chain.sv
// Registered pass-through pipeline with an optional tristate drive onto a shared bus,
// guarded by a direction FSM with turnaround cycles. Option: BIDIR_PORT_CHAIN_SYNC_EN.
module bidir_port_chain #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 2,
    parameter int TURNAROUND = 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    inout  wire  [WIDTH-1:0] IO,
    input  logic             dir_valid,
    input  logic             dir_req,
    output logic             dir_ready,
    output logic             driving,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid
);

    typedef enum logic [1:0] {
        RX      = 2'd0,
        TURN_TX = 2'd1,
        TX      = 2'd2,
        TURN_RX = 2'd3
    } state_t;

    localparam logic [2:0] TURN_LOAD = 3'(TURNAROUND);

    logic [WIDTH-1:0] pipe_p [DEPTH];
    state_t           state;
    logic [2:0]       cnt;

    // Pipeline stages: unconditional shift, stage DEPTH-1 is the output.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int s = 0; s < DEPTH; s++) pipe_p[s] <= '0;
        end else begin
            pipe_p[0] <= I;
            for (int s = 1; s < DEPTH; s++) pipe_p[s] <= pipe_p[s-1];
        end
    end

    assign O  = pipe_p[DEPTH-1];
    assign IO = driving ? O : {WIDTH{1'bz}};

    // Direction FSM; driving and dir_ready are registered alongside the state.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= RX;
            cnt       <= '0;
            driving   <= 1'b0;
            dir_ready <= 1'b1;
        end else begin
            case (state)
                RX: begin
                    if (dir_valid && dir_ready && dir_req) begin
                        if (TURNAROUND == 0) begin
                            state   <= TX;
                            driving <= 1'b1;
                        end else begin
                            state     <= TURN_TX;
                            cnt       <= TURN_LOAD;
                            dir_ready <= 1'b0;
                        end
                    end
                end
                TX: begin
                    if (dir_valid && dir_ready && !dir_req) begin
                        driving <= 1'b0;
                        if (TURNAROUND == 0) begin
                            state <= RX;
                        end else begin
                            state     <= TURN_RX;
                            cnt       <= TURN_LOAD;
                            dir_ready <= 1'b0;
                        end
                    end
                end
                TURN_TX: begin
                    if (cnt == 3'd1) begin
                        state     <= TX;
                        driving   <= 1'b1;
                        dir_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                TURN_RX: begin
                    if (cnt == 3'd1) begin
                        state     <= RX;
                        dir_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state     <= RX;
                    driving   <= 1'b0;
                    dir_ready <= 1'b1;
                end
            endcase
        end
    end

    logic             in_rx;
    logic [WIDTH-1:0] rx_src;
    logic             rx_take;

    assign in_rx = (state == RX);

`ifdef BIDIR_PORT_CHAIN_SYNC_EN
    logic [WIDTH-1:0] io_p0, io_p1;
    logic             vld_p0, vld_p1;

    // Two-flop synchroniser; the RX qualifier is delayed by the same two edges.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            io_p0  <= '0;
            io_p1  <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            io_p0  <= IO;
            io_p1  <= io_p0;
            vld_p0 <= in_rx;
            vld_p1 <= vld_p0;
        end
    end

    assign rx_src  = io_p1;
    assign rx_take = vld_p1;
`else
    assign rx_src  = IO;
    assign rx_take = in_rx;
`endif

    // Capture stage: rx_data holds outside RX.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= rx_take;
            if (rx_take) rx_data <= rx_src;
        end
    end

endmodule

// File: tb/tb_bidir_port_chain.sv
// Bench for bidir_port_chain: directed steps then random traffic, checked against
// a time-indexed reference model (O(n)=I(n-DEPTH), direction settles TURNAROUND edges after accept).
`timescale 1ns/1ps
module tb_bidir_port_chain;
    localparam int W    = 8;
    localparam int D    = 2;
    localparam int N    = 4;
    localparam int HMAX = 2048;
`ifdef BIDIR_PORT_CHAIN_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    logic [W-1:0] in_d [N];
    logic         dv   [N];
    logic         dq   [N];
    wire  [W-1:0] o    [N];
    wire          rdy  [N];
    wire          drv  [N];
    wire          rxv  [N];
    wire  [W-1:0] rxd  [N];

    wire  [W-1:0] bus0, bus1, bus2;
    logic         ext_en [3];
    logic [W-1:0] ext_v  [3];
    assign bus0 = ext_en[0] ? ext_v[0] : {W{1'bz}};
    assign bus1 = ext_en[1] ? ext_v[1] : {W{1'bz}};
    assign bus2 = ext_en[2] ? ext_v[2] : {W{1'bz}};

    bidir_port_chain #(.WIDTH(W), .DEPTH(D), .TURNAROUND(2)) u0 (
        .clk(clk), .arst(arst), .I(in_d[0]), .O(o[0]), .IO(bus0),
        .dir_valid(dv[0]), .dir_req(dq[0]), .dir_ready(rdy[0]), .driving(drv[0]),
        .rx_data(rxd[0]), .rx_valid(rxv[0]));
    bidir_port_chain #(.WIDTH(W), .DEPTH(D), .TURNAROUND(0)) u1 (
        .clk(clk), .arst(arst), .I(in_d[1]), .O(o[1]), .IO(bus1),
        .dir_valid(dv[1]), .dir_req(dq[1]), .dir_ready(rdy[1]), .driving(drv[1]),
        .rx_data(rxd[1]), .rx_valid(rxv[1]));
    bidir_port_chain #(.WIDTH(W), .DEPTH(D), .TURNAROUND(1)) ua (
        .clk(clk), .arst(arst), .I(in_d[2]), .O(o[2]), .IO(bus2),
        .dir_valid(dv[2]), .dir_req(dq[2]), .dir_ready(rdy[2]), .driving(drv[2]),
        .rx_data(rxd[2]), .rx_valid(rxv[2]));
    bidir_port_chain #(.WIDTH(W), .DEPTH(D), .TURNAROUND(1)) ub (
        .clk(clk), .arst(arst), .I(in_d[3]), .O(o[3]), .IO(bus2),
        .dir_valid(dv[3]), .dir_req(dq[3]), .dir_ready(rdy[3]), .driving(drv[3]),
        .rx_data(rxd[3]), .rx_valid(rxv[3]));

    // Reference model: per-edge history arrays plus target direction and settle edge.
    int           tcfg [N] = '{2, 0, 1, 1};
    int           bof  [N] = '{0, 1, 2, 2};
    int           e;
    logic         m_dir    [N];
    int           m_settle [N];
    logic [W-1:0] m_rxd    [N];
    logic         m_rxv    [N];
    logic [W-1:0] hin [N][HMAX];
    logic         hrx [N][HMAX];
    logic [W-1:0] hio [N][HMAX];

    int checks   = 0;
    int failures = 0;

    function automatic logic m_turn(int k);
        return (e - 1) < m_settle[k];
    endfunction
    function automatic logic m_drv(int k);
        return !m_turn(k) && m_dir[k];
    endfunction
    function automatic logic m_rdy(int k);
        return !m_turn(k);
    endfunction
    function automatic logic m_isrx(int k);
        return !m_turn(k) && !m_dir[k];
    endfunction
    function automatic logic [W-1:0] m_o(int k);
        return (e >= D) ? hin[k][e-D] : '0;
    endfunction
    function automatic logic [W-1:0] m_bus(int b);
        for (int k = 0; k < N; k++)
            if (bof[k] == b && m_drv(k)) return m_o(k);
        return ext_v[b];
    endfunction
    function automatic logic [W-1:0] bus_now(int b);
        case (b)
            0:       return bus0;
            1:       return bus1;
            default: return bus2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd_ext();
        for (int b = 0; b < 3; b++) begin
            ext_en[b] = 1'b1;
            for (int k = 0; k < N; k++)
                if (bof[k] == b && m_drv(k)) ext_en[b] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("O[%0d]", k),         o[k],        m_o(k));
            chk($sformatf("driving[%0d]", k),   W'(drv[k]),  W'(m_drv(k)));
            chk($sformatf("dir_ready[%0d]", k), W'(rdy[k]),  W'(m_rdy(k)));
            chk($sformatf("rx_valid[%0d]", k),  W'(rxv[k]),  W'(m_rxv[k]));
            chk($sformatf("rx_data[%0d]", k),   rxd[k],      m_rxd[k]);
        end
        for (int b = 0; b < 3; b++)
            chk($sformatf("IO[%0d]", b), bus_now(b), m_bus(b));
        chk("no_contention", W'(drv[2] && drv[3]), W'(0));
    endtask

    task automatic tick();
        logic         rdy_pre [N];
        logic         rx_pre  [N];
        logic [W-1:0] bv      [N];
        if (e >= HMAX - 1) begin
            $display("FAIL history_overflow observed=%0d required<%0d", e, HMAX);
            $fatal(1);
        end
        for (int k = 0; k < N; k++) begin
            rdy_pre[k] = m_rdy(k);
            rx_pre[k]  = m_isrx(k);
            bv[k]      = m_bus(bof[k]);
        end
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            hin[k][e] = in_d[k];
            hrx[k][e] = rx_pre[k];
            hio[k][e] = bv[k];
            if (dv[k] && rdy_pre[k] && dq[k] != m_dir[k]) begin
                m_dir[k]    = dq[k];
                m_settle[k] = e + tcfg[k];
            end
        end
        e++;
        for (int k = 0; k < N; k++) begin
            int j;
            j = e - 1 - L;
            if (j >= 0) begin
                m_rxv[k] = hrx[k][j];
                if (hrx[k][j]) m_rxd[k] = hio[k][j];
            end else begin
                m_rxv[k] = 1'b0;
            end
        end
        #1;
        upd_ext();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        arst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_driving[%0d]", k),   W'(drv[k]), W'(0));
            chk($sformatf("rst_O[%0d]", k),         o[k],       W'(0));
            chk($sformatf("rst_dir_ready[%0d]", k), W'(rdy[k]), W'(1));
        end
        e = 0;
        for (int k = 0; k < N; k++) begin
            m_dir[k]    = 1'b0;
            m_settle[k] = -100;
            m_rxd[k]    = '0;
            m_rxv[k]    = 1'b0;
        end
        upd_ext();
        #1;
        for (int b = 0; b < 3; b++)
            chk($sformatf("rst_IO[%0d]", b), bus_now(b), ext_v[b]);
        @(negedge clk);
        @(negedge clk);
        check_all();
        arst = 1'b0;
    endtask

    initial begin
        int n;
        arst = 1'b0;
        for (int k = 0; k < N; k++) begin
            in_d[k] = '0;
            dv[k]   = 1'b0;
            dq[k]   = 1'b0;
        end
        for (int b = 0; b < 3; b++) begin
            ext_v[b]  = W'($urandom);
            ext_en[b] = 1'b1;
        end
        #2;
        do_reset();

        // Pipeline latency with idle bus
        in_d[0] = 8'hA5;
        tick();
        in_d[0] = 8'h00;
        tick();
        chk("pipe_a5", o[0], 8'hA5);
        chk("idle_not_driving", W'(drv[0]), W'(0));

        // RX sampling of an external value
        ext_v[0] = 8'h3C;
        for (int c = 0; c <= L; c++) tick();
        chk("rx_3c", rxd[0], 8'h3C);
        chk("rx_3c_valid", W'(rxv[0]), W'(1));

        // RX -> TX with TURNAROUND=2
        dv[0] = 1'b1; dq[0] = 1'b1;
        tick();
        dv[0] = 1'b0;
        chk("turn_tx_ready", W'(rdy[0]), W'(0));
        n = 1;
        while (!drv[0] && n < 12) begin tick(); n++; end
        chk("tx_latency", W'(n), W'(3));
        chk("tx_io_eq_o", bus0, o[0] === m_o(0) ? m_o(0) : ~o[0]);

        // TX -> RX, symmetric
        dv[0] = 1'b1; dq[0] = 1'b0;
        tick();
        dv[0] = 1'b0;
        n = 1;
        while (!rdy[0] && n < 12) begin tick(); n++; end
        chk("rx_latency", W'(n), W'(3));
        chk("back_in_rx_driving", W'(drv[0]), W'(0));

        // Request held through TURN_TX is accepted only once ready
        dv[0] = 1'b1; dq[0] = 1'b1;
        tick();
        dq[0] = 1'b0;
        tick();
        chk("held_ignored", W'(rdy[0]), W'(0));
        tick();
        chk("held_tx_reached", W'(drv[0]), W'(1));
        tick();
        chk("held_accepted", W'(drv[0]), W'(0));
        chk("held_turn_rx", W'(rdy[0]), W'(0));
        dv[0] = 1'b0;
        for (int c = 0; c < 3; c++) tick();

        // TURNAROUND=0 and a redundant request
        dv[1] = 1'b1; dq[1] = 1'b1;
        tick();
        chk("t0_driving", W'(drv[1]), W'(1));
        tick();
        chk("t0_redundant_driving", W'(drv[1]), W'(1));
        chk("t0_redundant_ready", W'(rdy[1]), W'(1));
        dv[1] = 1'b0;

        // Chained pair: A to TX, then swap directions together
        in_d[2] = 8'h5A;
        dv[2] = 1'b1; dq[2] = 1'b1;
        tick();
        dv[2] = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("chain_a_tx", W'(drv[2]), W'(1));
        dv[2] = 1'b1; dq[2] = 1'b0;
        dv[3] = 1'b1; dq[3] = 1'b1;
        tick();
        dv[2] = 1'b0; dv[3] = 1'b0;
        chk("chain_b_got_5a", rxd[3], 8'h5A);
        for (int c = 0; c < 3; c++) tick();
        chk("chain_b_tx", W'(drv[3]), W'(1));
        chk("chain_a_rx", W'(drv[2]), W'(0));

        // Asynchronous reset while u0 is transmitting
        dv[0] = 1'b1; dq[0] = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        dv[0] = 1'b0;
        chk("pre_reset_tx", W'(drv[0]), W'(1));
        #2;
        do_reset();

        // Random traffic on the two standalone instances
        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < 2; k++) begin
                in_d[k] = W'($urandom);
                dv[k]   = 1'($urandom_range(0, 1));
                dq[k]   = 1'($urandom_range(0, 1));
            end
            in_d[2] = W'($urandom);
            in_d[3] = W'($urandom);
            for (int b = 0; b < 3; b++) ext_v[b] = W'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

endmodule
